wall_clk_reader: RTL and testbench
==================================

Name: wall_clk_reader

Overview:
- Memory-mapped consumer of the free-running millisecond count `cnt_val` produced by the wall-clock counter inside the custom_cpu wrapper.
- Exposes the count to the CPU or bench over a valid/ready request/response port.
- Provides a snapshot register, a start-relative elapsed-time register, and a compare-match interrupt, so software can time benchmark regions and sleep on deadlines.

Parameters:
- ADDR_W, 5, request address width (byte address; only word-aligned offsets 0x00–0x10 decode)
- CNT_W, 32, width of cnt_val and of all timer registers

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- cnt_val  in  CNT_W  wall-clock count from the wall-clock counter; same clk domain; increments by at most 1 per cycle
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  register offset
- req_wdata  in  CNT_W  write data
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid & resp_ready
- resp_rdata  out  CNT_W  read data; 0 for writes and unmapped addresses
- irq  out  1  level interrupt = pending & irq_en

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock; resetn asserted clears all state immediately, independent of clk.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, SNAP=0, START=0, CMP=0xFFFFFFFF, irq_en=0, pending=0, irq=0, cnt_prev=0.
- Register map:
  - 0x00 CNT (RO): live cnt_val. A read also loads SNAP with the same value.
  - 0x04 SNAP (RO).
  - 0x08 CMP (RW).
  - 0x0C CTRL: bit0 irq_en (RW); bit1 pending (read; write 1 clears); bit2 write 1 loads START := cnt_val (reads as 0).
  - 0x10 ELAPSED (RO): cnt_val − START, modulo 2^CNT_W, so wrap-around yields the correct delta.
  - Other offsets: reads return 0; writes are ignored. Any response is still returned.
- FSM with two states:
  - IDLE: req_ready=1. On handshake, perform the register side effect and capture rdata, both from cnt_val sampled at that edge; go to RESP.
  - RESP: req_ready=0, resp_valid=1. resp_rdata is held stable until resp_ready; then go to IDLE.
  - Back-to-back throughput is one transaction per 2 cycles minimum.
- Latency: request accepted at edge N → resp_valid high after edge N; earliest consumption at edge N+1.
- Compare match:
  - cnt_prev <= cnt_val every cycle.
  - match = (cnt_val != cnt_prev) & (cnt_val == CMP). Only fires on a count change, so a static equal value fires once.
  - match sets pending regardless of irq_en.
  - CMP write where new CMP equals the current cnt_val: no match until cnt_val next equals CMP after a change.
- Simultaneous events:
  - Match and W1C of pending in the same cycle: set wins, pending stays 1.
  - CNT read while cnt_val changes: the value sampled at the accept edge is used for both SNAP and rdata.
  - START load and ELAPSED read cannot coincide (one request at a time).
- Reset mid-transaction: an outstanding response is dropped (resp_valid→0 immediately); the requester must reissue.
- req_valid deasserted while in RESP has no effect; requests are not buffered.

Decomposition:
- Shared package holds:
  - Register offset constants: WCR_CNT, WCR_SNAP, WCR_CMP, WCR_CTRL, WCR_ELAPSED.
  - CTRL bit indices: IRQ_EN, PEND, START.
  - FSM state encoding: IDLE, RESP.
  - CMP reset value.
- One natural sub-module, wall_clk_match: holds cnt_prev and the change/equality detect, and outputs match.

Test Plan:
- Reset value: reset, then cnt_val=0x00000010; read 0x00 → rdata 0x10, response one cycle after accept; then read 0x04 → 0x10 even after cnt_val moves to 0x12.
- ELAPSED: write CTRL=0x4 with cnt_val=100; advance cnt_val to 135; read 0x10 → 35. Repeat with START captured at 0xFFFFFFFE and cnt_val=3 → ELAPSED 5.
- Compare interrupt: write CMP=50 and CTRL=0x1; step cnt_val 48→49→50. pending=1 and irq=1 the cycle after cnt_val becomes 50; hold cnt_val at 50 with no re-fire after a W1C (CTRL=0x3 written) → irq=0.
- Set-wins collision: arrange a W1C of pending in the same cycle as a new match → pending remains 1 and irq stays 1.
- Backpressure: issue a read with resp_ready=0 for 5 cycles → resp_valid and rdata stable and req_ready=0 throughout. A second req_valid held high is accepted only after the first response handshake.
- Reset mid-operation: assert resetn=0 asynchronously while resp_valid=1 → resp_valid, irq, pending and SNAP clear without a clk edge; CMP reads back 0xFFFFFFFF afterwards.

Source files
------------

// File: rtl/wall_clk_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wall_clk_reader_pkg                                        |
// | Description : Shared constants and types for the wall-clock reader:      |
// |               register offsets, CTRL bit positions, FSM encoding and     |
// |               the compare-register reset value.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package wall_clk_reader_pkg;

   // Byte offsets of the memory-mapped registers
   localparam int unsigned WCR_CNT     = 'h00;
   localparam int unsigned WCR_SNAP    = 'h04;
   localparam int unsigned WCR_CMP     = 'h08;
   localparam int unsigned WCR_CTRL    = 'h0C;
   localparam int unsigned WCR_ELAPSED = 'h10;

   // CTRL register bit positions
   localparam int IRQ_EN = 0;   // interrupt enable (RW)
   localparam int PEND   = 1;   // pending flag (read, write-1-to-clear)
   localparam int START  = 2;   // write 1 loads START from the live count

   // Request/response FSM encoding
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } wcr_state_e;

   // CMP resets to all-ones so no match fires until software programs it
   localparam logic [31:0] WCR_CMP_RST = 32'hFFFF_FFFF;

endpackage : wall_clk_reader_pkg
`default_nettype wire

// File: rtl/wall_clk_reader_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wall_clk_match                                             |
// | Description : Compare-match detector. Remembers the previous count and   |
// |               flags a match only when the count has just changed to the  |
// |               compare value, so a static equal count fires once.         |
// | Ports       : clk, resetn    - clock, async active-low reset             |
// |               i_cnt_val      - live wall-clock count                     |
// |               i_cmp          - compare value                             |
// |               o_match        - single-cycle match pulse (combinational)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wall_clk_match
   import wall_clk_reader_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [CNT_W-1:0] i_cnt_val,
   input  logic [CNT_W-1:0] i_cmp,
   output logic             o_match
);

   logic [CNT_W-1:0] r_cnt_prev;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt_prev <= '0;
      end else begin
         r_cnt_prev <= i_cnt_val;
      end
   end

   // Qualifying with a change means rewriting CMP to the current count does
   // not fire until the count moves away and comes back.
   assign o_match = (i_cnt_val != r_cnt_prev) && (i_cnt_val == i_cmp);

endmodule : wall_clk_match
`default_nettype wire

// File: rtl/wall_clk_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wall_clk_reader                                            |
// | Description : Memory-mapped reader of the free-running millisecond       |
// |               count. Provides live count, snapshot, compare-match        |
// |               interrupt and start-relative elapsed time over a           |
// |               valid/ready request/response port.                         |
// | Ports       : clk, resetn           - clock, async active-low reset      |
// |               cnt_val               - wall-clock count (same domain)     |
// |               req_valid/req_ready   - request handshake                  |
// |               req_wen/addr/wdata    - request fields                     |
// |               resp_valid/resp_ready - response handshake                 |
// |               resp_rdata            - read data (0 for writes/unmapped)  |
// |               irq                   - level interrupt pending & irq_en   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wall_clk_reader
   import wall_clk_reader_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [CNT_W-1:0]  cnt_val,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [CNT_W-1:0]  req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [CNT_W-1:0]  resp_rdata,
   output logic              irq
);

   localparam logic [ADDR_W-1:0] c_A_CNT     = ADDR_W'(WCR_CNT);
   localparam logic [ADDR_W-1:0] c_A_SNAP    = ADDR_W'(WCR_SNAP);
   localparam logic [ADDR_W-1:0] c_A_CMP     = ADDR_W'(WCR_CMP);
   localparam logic [ADDR_W-1:0] c_A_CTRL    = ADDR_W'(WCR_CTRL);
   localparam logic [ADDR_W-1:0] c_A_ELAPSED = ADDR_W'(WCR_ELAPSED);
   localparam logic [CNT_W-1:0]  c_CMP_RST   = CNT_W'(WCR_CMP_RST);

   wcr_state_e       r_state;
   wcr_state_e       w_state_nxt;
   logic             w_req_ready;
   logic             w_resp_valid;

   logic [CNT_W-1:0] r_rdata;
   logic [CNT_W-1:0] r_snap;
   logic [CNT_W-1:0] r_start;
   logic [CNT_W-1:0] r_cmp;
   logic             r_irq_en;
   logic             r_pending;

   logic             w_accept;
   logic             w_wr;
   logic             w_rd;
   logic             w_ctrl_wr;
   logic             w_w1c;
   logic             w_match;
   logic [CNT_W-1:0] w_ctrl_rd;
   logic [CNT_W-1:0] w_rd_mux;

   // ---------------------------------------------------------------------
   // Request/response FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_resp_valid = 1'b1;
            if (resp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign req_ready  = w_req_ready;
   assign resp_valid = w_resp_valid;
   assign resp_rdata = r_rdata;

   // ---------------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------------
   assign w_accept  = req_valid & w_req_ready;
   assign w_wr      = w_accept & req_wen;
   assign w_rd      = w_accept & ~req_wen;
   assign w_ctrl_wr = w_wr & (req_addr == c_A_CTRL);
   assign w_w1c     = w_ctrl_wr & req_wdata[PEND];

   always_comb begin
      w_ctrl_rd         = '0;
      w_ctrl_rd[IRQ_EN] = r_irq_en;
      w_ctrl_rd[PEND]   = r_pending;
   end

   // Read data is taken from the count at the accept edge; ELAPSED relies on
   // modular subtraction so a wrapped count still gives the right delta.
   always_comb begin
      w_rd_mux = '0;
      case (req_addr)
         c_A_CNT:     w_rd_mux = cnt_val;
         c_A_SNAP:    w_rd_mux = r_snap;
         c_A_CMP:     w_rd_mux = r_cmp;
         c_A_CTRL:    w_rd_mux = w_ctrl_rd;
         c_A_ELAPSED: w_rd_mux = cnt_val - r_start;
         default:     w_rd_mux = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rdata   <= '0;
         r_snap    <= '0;
         r_start   <= '0;
         r_cmp     <= c_CMP_RST;
         r_irq_en  <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         // A new match wins over a same-cycle write-1-to-clear
         r_pending <= w_match | (r_pending & ~w_w1c);

         if (w_accept) begin
            r_rdata <= req_wen ? '0 : w_rd_mux;
         end
         if (w_rd && (req_addr == c_A_CNT)) begin
            r_snap <= cnt_val;
         end
         if (w_wr && (req_addr == c_A_CMP)) begin
            r_cmp <= req_wdata;
         end
         if (w_ctrl_wr) begin
            r_irq_en <= req_wdata[IRQ_EN];
            if (req_wdata[START]) begin
               r_start <= cnt_val;
            end
         end
      end
   end

   assign irq = r_pending & r_irq_en;

   // ---------------------------------------------------------------------
   // Compare-match detector
   // ---------------------------------------------------------------------
   wall_clk_match #(
      .CNT_W (CNT_W)
   ) u_match (
      .clk       (clk),
      .resetn    (resetn),
      .i_cnt_val (cnt_val),
      .i_cmp     (r_cmp),
      .o_match   (w_match)
   );

endmodule : wall_clk_reader
`default_nettype wire

// File: tb/tb_wall_clk_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wall_clk_reader                                         |
// | Description : Self-checking bench for wall_clk_reader. Directed          |
// |               scenarios plus a randomized run compared cycle by cycle    |
// |               against a register-map level reference model.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wall_clk_reader;

   localparam int ADDR_W = 5;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              resetn;
   logic [CNT_W-1:0]  cnt_val;
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [CNT_W-1:0]  req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [CNT_W-1:0]  resp_rdata;
   logic              irq;

   always #5 clk = ~clk;

   wall_clk_reader #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cnt_val    (cnt_val),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .irq        (irq)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: register contents plus "a response is outstanding"
   bit          m_busy;
   logic [31:0] m_rdata;
   logic [31:0] m_snap;
   logic [31:0] m_start;
   logic [31:0] m_cmp;
   bit          m_en;
   bit          m_pend;
   logic [31:0] m_prev;

   task automatic model_reset();
      m_busy  = 1'b0;
      m_rdata = 32'h0;
      m_snap  = 32'h0;
      m_start = 32'h0;
      m_cmp   = 32'hFFFF_FFFF;
      m_en    = 1'b0;
      m_pend  = 1'b0;
      m_prev  = 32'h0;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'h00:   return cnt_val;
         5'h04:   return m_snap;
         5'h08:   return m_cmp;
         5'h0C:   return {30'b0, m_pend, m_en};
         5'h10:   return cnt_val - m_start;
         default: return 32'h0;
      endcase
   endfunction

   // Apply one clock edge worth of register-map rules to the model
   task automatic model_edge();
      bit hit;
      bit clr;
      hit = (cnt_val != m_prev) && (cnt_val == m_cmp);
      clr = 1'b0;
      if (!m_busy) begin
         if (req_valid) begin
            m_busy = 1'b1;
            if (req_wen) begin
               m_rdata = 32'h0;
               if (req_addr == 5'h08) m_cmp = req_wdata;
               if (req_addr == 5'h0C) begin
                  m_en = req_wdata[0];
                  clr  = req_wdata[1];
                  if (req_wdata[2]) m_start = cnt_val;
               end
            end else begin
               m_rdata = m_read(req_addr);
               if (req_addr == 5'h00) m_snap = cnt_val;
            end
         end
      end else if (resp_ready) begin
         m_busy = 1'b0;
      end
      m_pend = hit || (m_pend && !clr);
      m_prev = cnt_val;
   endtask

   // One clock: edge, model update, then settle at the falling edge
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Full request/response transaction; ok reports a timely response
   task automatic do_txn(input logic wen, input logic [4:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit ok);
      int guard;
      guard      = 0;
      req_valid  = 1'b1;
      req_wen    = wen;
      req_addr   = a;
      req_wdata  = wd;
      resp_ready = 1'b0;
      while (req_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      tick();
      req_valid  = 1'b0;
      ok         = (resp_valid === 1'b1) && (guard < 20);
      rd         = resp_rdata;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #1;
      n_vec++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: ready=%b valid=%b rdata=%h irq=%b, expected 1 0 00000000 0",
                  req_ready, resp_valid, resp_rdata, irq);
      end
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_cnt_snap();
      logic [31:0] rd;
      bit ok;
      cnt_val = 32'h10;
      tick();
      do_txn(1'b0, 5'h00, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'h10) begin
         n_err++;
         $display("FAIL cnt_read: rdata=%h resp_on_time=%0b, expected 00000010 1", rd, ok);
      end
      cnt_val = 32'h11; tick();
      cnt_val = 32'h12; tick();
      do_txn(1'b0, 5'h04, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'h10) begin
         n_err++;
         $display("FAIL snap_read: rdata=%h resp_on_time=%0b, expected 00000010 1", rd, ok);
      end
   endtask

   task automatic test_elapsed();
      logic [31:0] st [2] = '{32'd100, 32'hFFFF_FFFE};
      logic [31:0] en [2] = '{32'd135, 32'd3};
      logic [31:0] ex [2] = '{32'd35, 32'd5};
      logic [31:0] rd;
      bit ok;
      for (int k = 0; k < 2; k++) begin
         cnt_val = st[k];
         tick();
         do_txn(1'b1, 5'h0C, 32'h4, rd, ok);
         cnt_val = en[k];
         tick();
         do_txn(1'b0, 5'h10, 32'h0, rd, ok);
         n_vec++;
         if (!ok || rd !== ex[k]) begin
            n_err++;
            $display("FAIL elapsed_%0d: rdata=%0d resp_on_time=%0b, expected %0d 1", k, rd, ok, ex[k]);
         end
      end
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      bit ok;
      cnt_val = 32'd40;
      tick();
      do_txn(1'b1, 5'h08, 32'd50, rd, ok);
      do_txn(1'b1, 5'h0C, 32'h1, rd, ok);
      cnt_val = 32'd48; tick();
      cnt_val = 32'd49; tick();
      cnt_val = 32'd50;
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL irq_early: irq=%b, expected 0", irq);
      end
      tick();
      n_vec++;
      if (irq !== 1'b1) begin
         n_err++;
         $display("FAIL irq_match: irq=%b, expected 1", irq);
      end
      do_txn(1'b0, 5'h0C, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'h3) begin
         n_err++;
         $display("FAIL ctrl_pending: rdata=%h, expected 00000003", rd);
      end
      do_txn(1'b1, 5'h0C, 32'h3, rd, ok);
      tick(); tick(); tick();
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL irq_no_refire: irq=%b, expected 0", irq);
      end
      do_txn(1'b0, 5'h0C, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'h1) begin
         n_err++;
         $display("FAIL ctrl_cleared: rdata=%h, expected 00000001", rd);
      end
   endtask

   task automatic test_set_wins();
      logic [31:0] rd;
      bit ok;
      cnt_val = 32'd60; tick();
      do_txn(1'b1, 5'h08, 32'd61, rd, ok);
      cnt_val = 32'd61; tick();
      do_txn(1'b1, 5'h08, 32'd62, rd, ok);
      // W1C accepted on the same edge the count reaches the new CMP
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 5'h0C; req_wdata = 32'h3;
      cnt_val   = 32'd62;
      tick();
      req_valid = 1'b0;
      n_vec++;
      if (irq !== 1'b1 || resp_valid !== 1'b1) begin
         n_err++;
         $display("FAIL set_wins: irq=%b valid=%b, expected 1 1", irq, resp_valid);
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      do_txn(1'b0, 5'h0C, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'h3) begin
         n_err++;
         $display("FAIL set_wins_ctrl: rdata=%h, expected 00000003", rd);
      end
      do_txn(1'b1, 5'h0C, 32'h3, rd, ok);
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL set_wins_clear: irq=%b, expected 0", irq);
      end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 5'h08; req_wdata = 32'h0;
      resp_ready = 1'b0;
      tick();
      req_addr = 5'h0C;   // second request held while the first is stalled
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'd62 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_%0d: valid=%b rdata=%0d ready=%b, expected 1 62 0",
                     i, resp_valid, resp_rdata, req_ready);
         end
         cnt_val = cnt_val + 1;
         tick();
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      n_vec++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle: ready=%b valid=%b, expected 1 0", req_ready, resp_valid);
      end
      tick();
      req_valid = 1'b0;
      n_vec++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h1) begin
         n_err++;
         $display("FAIL b2b_second: valid=%b rdata=%h, expected 1 00000001", resp_valid, resp_rdata);
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         n_vec++;
         if (req_ready !== !m_busy || resp_valid !== m_busy ||
             (m_busy && resp_rdata !== m_rdata) || irq !== (m_pend & m_en)) begin
            n_err++;
            $display("FAIL random_%0d: ready=%b valid=%b rdata=%h irq=%b, expected %b %b %h %b",
                     i, req_ready, resp_valid, resp_rdata, irq,
                     !m_busy, m_busy, m_rdata, m_pend & m_en);
         end
         req_valid  = ($urandom_range(0, 1) == 1);
         req_wen    = ($urandom_range(0, 4) < 2);
         req_addr   = ($urandom_range(0, 5) < 5) ? 5'(4 * $urandom_range(0, 4))
                                                 : 5'($urandom_range(0, 31));
         if (req_addr == 5'h08)      req_wdata = cnt_val + $urandom_range(0, 4);
         else if (req_addr == 5'h0C) req_wdata = 32'($urandom_range(0, 7));
         else                        req_wdata = $urandom;
         resp_ready = ($urandom_range(0, 2) != 0);
         cnt_val    = cnt_val + $urandom_range(0, 1);
         tick();
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      tick(); tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      bit ok;
      do_txn(1'b1, 5'h08, cnt_val + 1, rd, ok);
      do_txn(1'b1, 5'h0C, 32'h1, rd, ok);
      cnt_val = cnt_val + 1;
      tick(); tick();
      do_txn(1'b0, 5'h00, 32'h0, rd, ok);
      n_vec++;
      if (irq !== 1'b1 || rd !== cnt_val) begin
         n_err++;
         $display("FAIL pre_reset: irq=%b rdata=%h, expected 1 %h", irq, rd, cnt_val);
      end
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 5'h04;
      tick();
      req_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      n_vec++;
      if (resp_valid !== 1'b0 || irq !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL async_reset: valid=%b irq=%b ready=%b rdata=%h, expected 0 0 1 00000000",
                  resp_valid, irq, req_ready, resp_rdata);
      end
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      do_txn(1'b0, 5'h04, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'h0) begin
         n_err++;
         $display("FAIL reset_snap: rdata=%h, expected 00000000", rd);
      end
      do_txn(1'b0, 5'h0C, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'h0) begin
         n_err++;
         $display("FAIL reset_ctrl: rdata=%h, expected 00000000", rd);
      end
      do_txn(1'b0, 5'h08, 32'h0, rd, ok);
      n_vec++;
      if (!ok || rd !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL reset_cmp: rdata=%h, expected ffffffff", rd);
      end
   endtask

   initial begin
      cnt_val    = 32'h0;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = '0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      model_reset();
      test_reset();
      test_cnt_snap();
      test_elapsed();
      test_irq();
      test_set_wins();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_wall_clk_reader
`default_nettype wire
